// File: rtl/ld_str_mem_port_pkg.sv
// Shared definitions for the load/store memory port: FSM encoding, default
// widths and the accept-state helper used by the top.
package ld_str_mem_port_pkg;

  localparam int N_DEF       = 32;
  localparam int TIMEOUT_DEF = 15;
  localparam int TW_DEF      = 4;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;
  localparam logic [1:0] ST_ERR  = 2'd3;

  // Every state except REQ can take a new op.
  function automatic logic is_accept_state(input logic [1:0] st);
    return (st != ST_REQ);
  endfunction

endpackage

// File: rtl/ld_str_mem_port_if.sv
// Data-memory bus between the load/store port (master) and the memory (slave).
interface ld_str_mem_port_if #(
  parameter int n = 32
) ();

  logic         mem_req;
  logic         mem_we;
  logic [n-1:0] mem_addr;
  logic [n-1:0] mem_wdata;
  logic [n-1:0] mem_rdata;
  logic         mem_ack;

  modport master (
    output mem_req,
    output mem_we,
    output mem_addr,
    output mem_wdata,
    input  mem_rdata,
    input  mem_ack
  );

  modport slave (
    input  mem_req,
    input  mem_we,
    input  mem_addr,
    input  mem_wdata,
    output mem_rdata,
    output mem_ack
  );

endinterface

// File: rtl/ld_str_mem_port_timeout_ctr.sv
// Request-cycle counter: cleared when an op is accepted, counts REQ cycles
// without ack, and flags the last allowed cycle.
module ld_str_mem_port_timeout_ctr #(
  parameter int TW      = 4,
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic clr,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam logic [TW-1:0] LAST = TW'(TIMEOUT - 1);

  logic [TW-1:0] cnt_q;
  logic [TW-1:0] cnt_d;

  assign expire = (cnt_q == LAST);

  // Next count; holding at LAST keeps the counter from ever wrapping.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = {TW{1'b0}};
    end else if (enable && !expire) begin
      cnt_d = cnt_q + TW'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!clr) begin
      cnt_q <= {TW{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/ld_str_mem_port.sv
// Load/store memory port: performs one latched load or store on the data bus
// with req/ack, returns load data, stalls the pipe while busy, times out.
module ld_str_mem_port
  import ld_str_mem_port_pkg::*;
#(
  parameter int n       = N_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF,
  parameter int TW      = TW_DEF
) (
  input  logic                 clk,
  input  logic                 clr,
  input  logic                 start,
  input  logic                 is_store,
  input  logic [n-1:0]         addr,
  input  logic [n-1:0]         wdata,
  ld_str_mem_port_if.master    mem,
  output logic [n-1:0]         rdata,
  output logic                 done,
  output logic                 err,
  output logic                 stall
);

  logic [1:0]   state_q, state_d;
  logic         req_q, req_d;
  logic         we_q, we_d;
  logic [n-1:0] addr_q, addr_d;
  logic [n-1:0] wdata_q, wdata_d;
  logic [n-1:0] rdata_q, rdata_d;
  logic         done_q, done_d;
  logic         err_q, err_d;

  logic accept_s;
  logic take_s;
  logic in_req_s;
  logic expire_s;

  assign accept_s = is_accept_state(state_q);
  assign take_s   = accept_s & start;
  assign in_req_s = (state_q == ST_REQ);

  ld_str_mem_port_timeout_ctr #(
    .TW      (TW),
    .TIMEOUT (TIMEOUT)
  ) u_timeout_ctr (
    .clk    (clk),
    .clr    (clr),
    .clear  (take_s),
    .enable (in_req_s & ~mem.mem_ack),
    .expire (expire_s)
  );

  // FSM next state; an ack in the final allowed cycle still wins over timeout.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_REQ;
        else       state_d = ST_IDLE;
      end
      ST_REQ: begin
        if (mem.mem_ack)   state_d = ST_DONE;
        else if (expire_s) state_d = ST_ERR;
        else               state_d = ST_REQ;
      end
      ST_DONE, ST_ERR: begin
        if (start) state_d = ST_REQ;
        else       state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath next values: request registers load on accept, rdata only on load ack.
  always_comb begin
    req_d   = (state_d == ST_REQ);
    done_d  = (state_d == ST_DONE) || (state_d == ST_ERR);
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    if (take_s) begin
      we_d    = is_store;
      addr_d  = addr;
      wdata_d = wdata;
      err_d   = 1'b0;
    end else if (in_req_s && (state_d == ST_ERR)) begin
      err_d   = 1'b1;
    end else begin
      err_d   = err_q;
    end
    if (in_req_s && mem.mem_ack && !we_q) begin
      rdata_d = mem.mem_rdata;
    end else begin
      rdata_d = rdata_q;
    end
  end

  // State and output registers, synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!clr) begin
      state_q <= ST_IDLE;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= {n{1'b0}};
      wdata_q <= {n{1'b0}};
      rdata_q <= {n{1'b0}};
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign mem.mem_req   = req_q;
  assign mem.mem_we    = we_q;
  assign mem.mem_addr  = addr_q;
  assign mem.mem_wdata = wdata_q;
  assign rdata         = rdata_q;
  assign done          = done_q;
  assign err           = err_q;
  assign stall         = req_q;

endmodule

// File: tb/tb_ld_str_mem_port.sv
// Bench for ld_str_mem_port: a scripted memory responder plus a scoreboard of
// expected completion results (err, rdata, request length) per issued op.
module tb_ld_str_mem_port;

  logic        clk;
  logic        clr;
  logic        start;
  logic        is_store;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        done;
  logic        err;
  logic        stall;

  ld_str_mem_port_if #(.n(32)) mif ();

  ld_str_mem_port #(.n(32), .TIMEOUT(15), .TW(4)) dut (
    .clk      (clk),
    .clr      (clr),
    .start    (start),
    .is_store (is_store),
    .addr     (addr),
    .wdata    (wdata),
    .mem      (mif),
    .rdata    (rdata),
    .done     (done),
    .err      (err),
    .stall    (stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    int          len;
  } exp_t;

  exp_t        sb[$];
  int          n_chk = 0;
  int          n_fail = 0;
  int          ack_after = 0;
  logic [31:0] rdata_next = 32'h0;
  logic        stray_ack = 1'b0;
  logic [31:0] model_rdata = 32'h0;
  int          req_run = 0;
  int          req_len = 0;
  int          stall_len = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Memory model: ack in the ack_after-th REQ cycle (0 = never); optional stray ack outside REQ.
  always @(negedge clk) begin
    mif.mem_ack = 1'b0;
    if (mif.mem_req) begin
      req_run++;
      if (req_run == ack_after) begin
        mif.mem_ack   = 1'b1;
        mif.mem_rdata = rdata_next;
      end
    end else begin
      req_run = 0;
      if (stray_ack) begin
        mif.mem_ack   = 1'b1;
        mif.mem_rdata = 32'hBAD0BAD0;
      end
    end
  end

  // Completion monitor: every done pulse pops one expectation.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (!clr) begin
      req_len   = 0;
      stall_len = 0;
    end else begin
      if (mif.mem_req) req_len++;
      if (stall) stall_len++;
      if (done) begin
        if (sb.size() == 0) begin
          check_eq("unexpected_done", {31'b0, done}, 32'd0);
        end else begin
          e = sb.pop_front();
          check_eq("done_err", {31'b0, err}, {31'b0, e.err});
          check_eq("done_rdata", rdata, e.rdata);
          check_eq("req_cycles", req_len, e.len);
          check_eq("stall_cycles", stall_len, e.len);
        end
        req_len   = 0;
        stall_len = 0;
      end
    end
  end

  // Drive one op from a negedge; return at the negedge after acceptance.
  task automatic issue(input logic st, input logic [31:0] a, input logic [31:0] wd,
                       input int k, input logic [31:0] rd);
    exp_t e;
    start      = 1'b1;
    is_store   = st;
    addr       = a;
    wdata      = wd;
    ack_after  = k;
    rdata_next = rd;
    if (!st && (k != 0)) model_rdata = rd;
    e.err   = (k == 0);
    e.rdata = model_rdata;
    e.len   = (k == 0) ? 15 : k;
    sb.push_back(e);
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    check_eq("issue_req", {31'b0, mif.mem_req}, 32'd1);
    check_eq("issue_stall", {31'b0, stall}, 32'd1);
    check_eq("issue_addr", mif.mem_addr, a);
    check_eq("issue_we", {31'b0, mif.mem_we}, {31'b0, st});
    check_eq("issue_err_clr", {31'b0, err}, 32'd0);
    if (st) check_eq("issue_wdata", mif.mem_wdata, wd);
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done && (n < 40)) begin
      @(negedge clk);
      n++;
    end
    check_eq("done_seen", {31'b0, done}, 32'd1);
  endtask

  initial begin
    clr = 1'b0; start = 1'b0; is_store = 1'b0; addr = 32'h0; wdata = 32'h0;
    repeat (2) @(negedge clk);
    check_eq("rst_req", {31'b0, mif.mem_req}, 32'd0);
    check_eq("rst_done", {31'b0, done}, 32'd0);
    check_eq("rst_err", {31'b0, err}, 32'd0);
    check_eq("rst_rdata", rdata, 32'h0);
    check_eq("rst_addr", mif.mem_addr, 32'h0);
    check_eq("rst_stall", {31'b0, stall}, 32'd0);
    clr = 1'b1;
    @(negedge clk);

    // Load with ack in the 4th REQ cycle.
    issue(1'b0, 32'h40, 32'h0, 4, 32'hDEADBEEF);
    wait_done();
    check_eq("load_req_low", {31'b0, mif.mem_req}, 32'd0);
    @(negedge clk);
    check_eq("load_done_pulse", {31'b0, done}, 32'd0);
    check_eq("load_rdata_hold", rdata, 32'hDEADBEEF);

    // Store with immediate ack leaves rdata alone.
    issue(1'b1, 32'h44, 32'h12345678, 1, 32'hCAFEF00D);
    wait_done();
    check_eq("store_rdata", rdata, 32'hDEADBEEF);
    @(negedge clk);

    // Back-to-back: start in the DONE cycle.
    issue(1'b0, 32'h48, 32'h0, 2, 32'h11112222);
    wait_done();
    issue(1'b1, 32'h4C, 32'hA5A5A5A5, 3, 32'h0);
    wait_done();
    check_eq("b2b_rdata", rdata, 32'h11112222);
    @(negedge clk);

    // Timeout, sticky err, cleared by next accepted op.
    issue(1'b0, 32'h50, 32'h0, 0, 32'h0BADF00D);
    wait_done();
    check_eq("to_err", {31'b0, err}, 32'd1);
    @(negedge clk);
    check_eq("to_err_sticky", {31'b0, err}, 32'd1);
    check_eq("to_done_pulse", {31'b0, done}, 32'd0);
    issue(1'b0, 32'h54, 32'h0, 1, 32'h33334444);
    wait_done();
    @(negedge clk);

    // Ack on the last allowed cycle wins; stray ack in IDLE is ignored.
    issue(1'b0, 32'h58, 32'h0, 15, 32'h55556666);
    wait_done();
    check_eq("race_err", {31'b0, err}, 32'd0);
    @(negedge clk);
    stray_ack = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("stray_done", {31'b0, done}, 32'd0);
    end
    stray_ack = 1'b0;

    // Reset in the middle of a request, then a late ack.
    issue(1'b0, 32'h60, 32'h0, 0, 32'h0);
    repeat (3) @(negedge clk);
    clr = 1'b0;
    @(negedge clk);
    check_eq("mid_rst_req", {31'b0, mif.mem_req}, 32'd0);
    check_eq("mid_rst_rdata", rdata, 32'h0);
    check_eq("mid_rst_err", {31'b0, err}, 32'd0);
    check_eq("mid_rst_done", {31'b0, done}, 32'd0);
    @(negedge clk);
    clr = 1'b1;
    sb.delete();
    model_rdata = 32'h0;
    stray_ack = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check_eq("late_ack_done", {31'b0, done}, 32'd0);
      check_eq("late_ack_req", {31'b0, mif.mem_req}, 32'd0);
    end
    stray_ack = 1'b0;
    @(negedge clk);
    check_eq("sb_empty", sb.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
